// File: rtl/dataflow_pkg.sv
// Shared encodings for the single-clock multicycle RV32I datapath:
// sequencer states, writeback selects, load/store size codes and opcodes.
package dataflow_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        TRAP  = 3'd5
    } state_t;

    localparam logic [1:0] RD_MEM = 2'd0;
    localparam logic [1:0] RD_IMM = 2'd1;
    localparam logic [1:0] RD_ALU = 2'd2;
    localparam logic [1:0] RD_PC  = 2'd3;

    localparam logic [2:0] MS_B  = 3'b000;
    localparam logic [2:0] MS_H  = 3'b001;
    localparam logic [2:0] MS_W  = 3'b010;
    localparam logic [2:0] MS_BU = 3'b100;
    localparam logic [2:0] MS_HU = 3'b101;

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] PC_INC = 32'd4;

    // Unsigned variants share the low two size bits with their signed forms.
    function automatic logic misaligned(input logic [2:0] ms, input logic [1:0] lo);
        case (ms[1:0])
            2'b10:   return lo != 2'b00;
            2'b01:   return lo[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dataflow_seq.sv
// Sequencer for the multicycle datapath: FSM, memory handshake outputs,
// register enables and the alignment trap check.
module dataflow_seq import dataflow_pkg::*; #(
    parameter bit TRAP_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_ready,
    input  logic       is_load,
    input  logic       is_store,
    input  logic       rd_we,
    input  logic [2:0] mem_s,
    input  logic [1:0] alu_lo,
    input  logic [1:0] pc_new_lo,
    output state_t     state,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_alu,
    output logic       insn_en,
    output logic       mdr_en,
    output logic       pc_en,
    output logic       rd_en,
    output logic       retire,
    output logic       trap
);

    state_t state_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_alu = 1'b0;
        insn_en  = 1'b0;
        mdr_en   = 1'b0;
        pc_en    = 1'b0;
        rd_en    = 1'b0;
        retire   = 1'b0;
        trap     = 1'b0;
        case (state)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    insn_en = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_load || is_store) begin
                    if (TRAP_EN && misaligned(mem_s, alu_lo)) state_d = TRAP;
                    else                                     state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                // Address and write strobe held on the ALU result until ready.
                mem_req  = 1'b1;
                mem_we   = is_store;
                addr_alu = 1'b1;
                if (mem_ready) begin
                    mdr_en  = is_load;
                    state_d = WB;
                end
            end
            WB: begin
                retire  = 1'b1;
                pc_en   = 1'b1;
                rd_en   = rd_we;
                state_d = (TRAP_EN && pc_new_lo != 2'b00) ? TRAP : FETCH;
            end
            TRAP:    trap = 1'b1;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/dataflow_mc.sv
// Single-clock multicycle RV32I datapath: PC, instruction/data latches,
// register file, immediate/load extension, ALU and next-PC logic.
module dataflow_mc import dataflow_pkg::*; #(
    parameter int          XLEN     = 32,
    parameter int          NREG     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          TRAP_EN  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    mem_req,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic [XLEN-1:0]         addr,
    output logic [XLEN-1:0]         wdata,
    input  logic [XLEN-1:0]         dout,
    input  logic                    pc_next_sel,
    input  logic                    pc_alu_sel,
    input  logic                    alu_a_sel,
    input  logic                    alu_b_sel,
    input  logic                    sub_sra,
    input  logic [1:0]              rd_sel,
    input  logic [2:0]              func3,
    input  logic [2:0]              mem_s,
    input  logic                    is_load,
    input  logic                    is_store,
    input  logic                    rd_we,
    input  logic [$clog2(NREG)-1:0] RSA,
    input  logic [$clog2(NREG)-1:0] RSB,
    input  logic [$clog2(NREG)-1:0] RD,
    output logic [XLEN-1:0]         insn_out,
    output logic                    EQ,
    output logic                    LS,
    output logic                    LU,
    output logic [2:0]              state,
    output logic                    retire,
    output logic                    trap
);

    localparam int RW = $clog2(NREG);

    state_t                 st;
    logic                   addr_alu, insn_en, mdr_en, pc_en, rd_en;
    logic [XLEN-1:0]        pc_q, insn_q, mdr_q;
    logic [XLEN-1:0]        imm, rs1, rs2, alu_a, alu_b, alu_y;
    logic signed [XLEN-1:0] alu_a_s, alu_b_s;
    logic [XLEN-1:0]        pc_add, pc_new, mem_x, rd_val;
    logic [4:0]             shamt;
    logic [XLEN-1:0]        rf [NREG];

    dataflow_seq #(.TRAP_EN(TRAP_EN)) u_seq (
        .clk      (clk),
        .reset    (reset),
        .mem_ready(mem_ready),
        .is_load  (is_load),
        .is_store (is_store),
        .rd_we    (rd_we),
        .mem_s    (mem_s),
        .alu_lo   (alu_y[1:0]),
        .pc_new_lo(pc_new[1:0]),
        .state    (st),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .addr_alu (addr_alu),
        .insn_en  (insn_en),
        .mdr_en   (mdr_en),
        .pc_en    (pc_en),
        .rd_en    (rd_en),
        .retire   (retire),
        .trap     (trap)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            insn_q <= '0;
            mdr_q  <= '0;
        end else begin
            if (pc_en)   pc_q   <= pc_new;
            if (insn_en) insn_q <= dout;
            if (mdr_en)  mdr_q  <= dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (rd_en && RD != '0) begin
            rf[RD] <= rd_val;
        end
    end

    assign rs1 = (RSA == RW'(0)) ? '0 : rf[RSA];
    assign rs2 = (RSB == RW'(0)) ? '0 : rf[RSB];

    always_comb begin
        case (insn_q[6:0])
            OP_STORE:        imm = {{20{insn_q[31]}}, insn_q[31:25], insn_q[11:7]};
            OP_BRANCH:       imm = {{19{insn_q[31]}}, insn_q[31], insn_q[7],
                                    insn_q[30:25], insn_q[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm = {insn_q[31:12], 12'b0};
            OP_JAL:          imm = {{11{insn_q[31]}}, insn_q[31], insn_q[19:12],
                                    insn_q[20], insn_q[30:21], 1'b0};
            default:         imm = {{20{insn_q[31]}}, insn_q[31:20]};
        endcase
    end

    assign alu_a   = alu_a_sel ? pc_q : rs1;
    assign alu_b   = alu_b_sel ? imm  : rs2;
    assign alu_a_s = alu_a;
    assign alu_b_s = alu_b;
    assign shamt   = alu_b[4:0];

    always_comb begin
        alu_y = '0;
        case (func3)
            3'b000: alu_y = sub_sra ? alu_a - alu_b : alu_a + alu_b;
            3'b001: alu_y = alu_a << shamt;
            3'b010: alu_y = {{(XLEN-1){1'b0}}, alu_a_s < alu_b_s};
            3'b011: alu_y = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            3'b100: alu_y = alu_a ^ alu_b;
            3'b101: alu_y = sub_sra ? alu_a_s >>> shamt : alu_a >> shamt;
            3'b110: alu_y = alu_a | alu_b;
            3'b111: alu_y = alu_a & alu_b;
            default: alu_y = '0;
        endcase
    end

    assign EQ = alu_a == alu_b;
    assign LS = alu_a_s < alu_b_s;
    assign LU = alu_a < alu_b;

    // pc+4 and pc+imm both come from this adder; rd_sel=3 writes it back too.
    assign pc_add = pc_q + (pc_alu_sel ? imm : PC_INC);
    assign pc_new = pc_next_sel ? alu_y : pc_add;

    always_comb begin
        case (mem_s)
            MS_B:    mem_x = {{24{mdr_q[7]}}, mdr_q[7:0]};
            MS_H:    mem_x = {{16{mdr_q[15]}}, mdr_q[15:0]};
            MS_BU:   mem_x = {24'b0, mdr_q[7:0]};
            MS_HU:   mem_x = {16'b0, mdr_q[15:0]};
            default: mem_x = mdr_q;
        endcase
    end

    always_comb begin
        case (rd_sel)
            RD_MEM:  rd_val = mem_x;
            RD_IMM:  rd_val = imm;
            RD_ALU:  rd_val = alu_y;
            default: rd_val = pc_add;
        endcase
    end

    assign addr     = addr_alu ? alu_y : pc_q;
    assign wdata    = rs2;
    assign insn_out = insn_q;
    assign state    = st;

endmodule

// File: tb/tb_dataflow_mc.sv
// Directed bench: an RV32E trapping instance and an RV32I non-trapping
// instance run the same hand-encoded program side by side.
module tb_dataflow_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_ready;
    logic [31:0] dout;
    logic        pc_next_sel, pc_alu_sel, alu_a_sel, alu_b_sel, sub_sra;
    logic [1:0]  rd_sel;
    logic [2:0]  func3, mem_s;
    logic        is_load, is_store, rd_we;
    logic [4:0]  rsa, rsb, rd;

    logic        a_req, a_we, a_eq, a_ls, a_lu, a_ret, a_trap;
    logic [31:0] a_addr, a_wdata, a_insn;
    logic [2:0]  a_state;
    logic        b_req, b_we, b_eq, b_ls, b_lu, b_ret, b_trap;
    logic [31:0] b_addr, b_wdata, b_insn;
    logic [2:0]  b_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dataflow_mc #(.NREG(16), .TRAP_EN(1'b1)) u_e16 (
        .clk(clk), .reset(reset), .mem_req(a_req), .mem_we(a_we), .mem_ready(mem_ready),
        .addr(a_addr), .wdata(a_wdata), .dout(dout),
        .pc_next_sel(pc_next_sel), .pc_alu_sel(pc_alu_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .sub_sra(sub_sra), .rd_sel(rd_sel), .func3(func3),
        .mem_s(mem_s), .is_load(is_load), .is_store(is_store), .rd_we(rd_we),
        .RSA(rsa[3:0]), .RSB(rsb[3:0]), .RD(rd[3:0]), .insn_out(a_insn),
        .EQ(a_eq), .LS(a_ls), .LU(a_lu), .state(a_state), .retire(a_ret), .trap(a_trap)
    );

    dataflow_mc #(.NREG(32), .TRAP_EN(1'b0)) u_nt (
        .clk(clk), .reset(reset), .mem_req(b_req), .mem_we(b_we), .mem_ready(mem_ready),
        .addr(b_addr), .wdata(b_wdata), .dout(dout),
        .pc_next_sel(pc_next_sel), .pc_alu_sel(pc_alu_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .sub_sra(sub_sra), .rd_sel(rd_sel), .func3(func3),
        .mem_s(mem_s), .is_load(is_load), .is_store(is_store), .rd_we(rd_we),
        .RSA(rsa), .RSB(rsb), .RD(rd), .insn_out(b_insn),
        .EQ(b_eq), .LS(b_ls), .LU(b_lu), .state(b_state), .retire(b_ret), .trap(b_trap)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic dec(input logic pcn, input logic pca, input logic as_, input logic bs,
                       input logic sub, input logic [1:0] rs, input logic [2:0] f3,
                       input logic [2:0] ms, input logic ld, input logic st, input logic we,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rdi);
        pc_next_sel = pcn; pc_alu_sel = pca; alu_a_sel = as_; alu_b_sel = bs;
        sub_sra = sub; rd_sel = rs; func3 = f3; mem_s = ms;
        is_load = ld; is_store = st; rd_we = we; rsa = ra; rsb = rb; rd = rdi;
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b0; dout = '0;
        dec(0, 0, 0, 0, 0, 2'd0, 3'd0, 3'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step(); step();
        chk("rst_state", {29'b0, a_state}, 32'd0);
        chk("rst_req", {31'b0, a_req}, 32'd0);
        chk("rst_we", {31'b0, a_we}, 32'd0);
        chk("rst_addr", a_addr, 32'h0);
        chk("rst_insn", a_insn, 32'h0);
        chk("rst_trap", {31'b0, a_trap}, 32'd0);
        chk("rst_retire", {31'b0, a_ret}, 32'd0);

        // ADDI x1,x0,5
        reset = 1'b1;
        dec(0, 0, 0, 1, 0, 2'd2, 3'd0, 3'd0, 0, 0, 1, 5'd0, 5'd0, 5'd1);
        step();
        chk("addi_fetch_state", {29'b0, a_state}, 32'd1);
        chk("addi_fetch_req", {31'b0, a_req}, 32'd1);
        chk("addi_fetch_addr", a_addr, 32'h0);
        dout = 32'h0050_0093; mem_ready = 1'b1;
        step();
        chk("addi_exec_state", {29'b0, a_state}, 32'd2);
        chk("addi_insn", a_insn, 32'h0050_0093);
        chk("addi_exec_req", {31'b0, a_req}, 32'd0);
        mem_ready = 1'b0; dout = '0;
        step();
        chk("addi_wb_state", {29'b0, a_state}, 32'd4);
        chk("addi_wb_retire", {31'b0, a_ret}, 32'd1);
        step();
        chk("addi_next_state", {29'b0, a_state}, 32'd1);
        chk("addi_retire_low", {31'b0, a_ret}, 32'd0);
        chk("addi_pc", a_addr, 32'h4);
        rsb = 5'd1; #1;
        chk("addi_x1", a_wdata, 32'h5);

        // LW x2,0x3B(x1) with three wait cycles in MEM
        dec(0, 0, 0, 1, 0, 2'd0, 3'd0, 3'b010, 1, 0, 1, 5'd1, 5'd2, 5'd2);
        dout = 32'h03B0_A103; mem_ready = 1'b1;
        step();
        chk("lw_exec_state", {29'b0, a_state}, 32'd2);
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("lw_mem_state", {29'b0, a_state}, 32'd3);
            chk("lw_mem_req", {31'b0, a_req}, 32'd1);
            chk("lw_mem_addr", a_addr, 32'h40);
            chk("lw_mem_we", {31'b0, a_we}, 32'd0);
        end
        mem_ready = 1'b1; dout = 32'hDEAD_BEEF;
        step();
        chk("lw_wb_state", {29'b0, a_state}, 32'd4);
        chk("lw_wb_retire", {31'b0, a_ret}, 32'd1);
        mem_ready = 1'b0; dout = 32'h0BAD_F00D;
        step();
        chk("lw_next_pc", a_addr, 32'h8);
        chk("lw_x2", a_wdata, 32'hDEAD_BEEF);
        rsa = 5'd2; rsb = 5'd1; #1;
        chk("flag_eq", {31'b0, a_eq}, 32'd0);
        chk("flag_ls", {31'b0, a_ls}, 32'd1);
        chk("flag_lu", {31'b0, a_lu}, 32'd0);

        // BEQ x0,x0,-4 at pc=8, taken
        dec(0, 1, 0, 0, 1, 2'd0, 3'd0, 3'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        dout = 32'hFE00_0EE3; mem_ready = 1'b1;
        step();
        chk("beq_exec_eq", {31'b0, a_eq}, 32'd1);
        mem_ready = 1'b0;
        step();
        step();
        chk("beq_pc", a_addr, 32'h4);

        // LH x6,0x3B(x1), zero-wait, sign-extended
        dec(0, 0, 0, 1, 0, 2'd0, 3'd0, 3'b001, 1, 0, 1, 5'd1, 5'd6, 5'd6);
        dout = 32'h03B0_9303; mem_ready = 1'b1;
        step();
        dout = 32'h1234_8001;
        step();
        chk("lh_mem_state", {29'b0, a_state}, 32'd3);
        chk("lh_mem_addr", a_addr, 32'h40);
        step();
        mem_ready = 1'b0;
        step();
        chk("lh_next_pc", a_addr, 32'h8);
        chk("lh_x6", a_wdata, 32'hFFFF_8001);

        // ADDI x3,x0,-4 ; JALR x0,0(x3) ; NOP at 0xFFFFFFFC wraps to 0
        dec(0, 0, 0, 1, 0, 2'd2, 3'd0, 3'd0, 0, 0, 1, 5'd0, 5'd3, 5'd3);
        dout = 32'hFFC0_0193; mem_ready = 1'b1;
        step(); step(); step();
        chk("addi_x3", a_wdata, 32'hFFFF_FFFC);
        chk("addi_x3_pc", a_addr, 32'hC);
        dec(1, 0, 0, 1, 0, 2'd3, 3'd0, 3'd0, 0, 0, 0, 5'd3, 5'd0, 5'd0);
        dout = 32'h0001_8067;
        step(); step(); step();
        chk("jalr_pc", a_addr, 32'hFFFF_FFFC);
        dec(0, 0, 0, 1, 0, 2'd2, 3'd0, 3'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        dout = 32'h0000_0013;
        step(); step(); step();
        chk("wrap_pc", a_addr, 32'h0);
        chk("wrap_pc_nt", b_addr, 32'h0);

        // SW x2,0xFD(x1): address 0x102 is misaligned
        dec(0, 0, 0, 1, 0, 2'd0, 3'd0, 3'b010, 0, 1, 0, 5'd1, 5'd2, 5'd0);
        dout = 32'h0E20_AEA3;
        step();
        chk("sw_exec_req", {31'b0, a_req}, 32'd0);
        mem_ready = 1'b0;
        step();
        chk("sw_trap_state", {29'b0, a_state}, 32'd5);
        chk("sw_trap_flag", {31'b0, a_trap}, 32'd1);
        chk("sw_trap_req", {31'b0, a_req}, 32'd0);
        chk("sw_nt_state", {29'b0, b_state}, 32'd3);
        chk("sw_nt_req", {31'b0, b_req}, 32'd1);
        chk("sw_nt_we", {31'b0, b_we}, 32'd1);
        chk("sw_nt_addr", b_addr, 32'h102);
        chk("sw_nt_wdata", b_wdata, 32'hDEAD_BEEF);
        step();
        chk("sw_nt_addr_hold", b_addr, 32'h102);
        mem_ready = 1'b1;
        step();
        chk("sw_nt_wb", {29'b0, b_state}, 32'd4);
        mem_ready = 1'b0;
        step();
        chk("sw_trap_sticky", {31'b0, a_trap}, 32'd1);
        chk("sw_trap_state2", {29'b0, a_state}, 32'd5);
        chk("sw_nt_next_pc", b_addr, 32'h4);

        // Reset leaves TRAP
        reset = 1'b0;
        step();
        chk("trap_rst_state", {29'b0, a_state}, 32'd0);
        chk("trap_rst_flag", {31'b0, a_trap}, 32'd0);
        chk("trap_rst_addr", a_addr, 32'h0);
        reset = 1'b1;
        step();
        chk("trap_rst_fetch", {29'b0, a_state}, 32'd1);

        // ADDI x0,x0,7 is discarded; ADDI x15,x0,0x123 via imm writeback
        dec(0, 0, 0, 1, 0, 2'd1, 3'd0, 3'd0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        dout = 32'h0070_0013; mem_ready = 1'b1;
        step(); step(); step();
        chk("x0_read", a_wdata, 32'h0);
        dec(0, 0, 0, 1, 0, 2'd1, 3'd0, 3'd0, 0, 0, 1, 5'd0, 5'd15, 5'd15);
        dout = 32'h1230_0793;
        step(); step(); step();
        chk("x15_pc", a_addr, 32'h8);
        chk("x15_read", a_wdata, 32'h123);
        chk("x15_read_nt", b_wdata, 32'h123);

        // SW x15,0x1D(x15), then reset during the MEM wait
        dec(0, 0, 0, 1, 0, 2'd0, 3'd0, 3'b010, 0, 1, 0, 5'd15, 5'd15, 5'd0);
        dout = 32'h00F7_AEA3;
        step();
        mem_ready = 1'b0;
        step();
        chk("sw15_state", {29'b0, a_state}, 32'd3);
        chk("sw15_addr", a_addr, 32'h140);
        chk("sw15_we", {31'b0, a_we}, 32'd1);
        chk("sw15_wdata", a_wdata, 32'h123);
        step();
        chk("sw15_req_hold", {31'b0, a_req}, 32'd1);
        reset = 1'b0;
        step();
        chk("mrst_state", {29'b0, a_state}, 32'd0);
        chk("mrst_req", {31'b0, a_req}, 32'd0);
        chk("mrst_we", {31'b0, a_we}, 32'd0);
        chk("mrst_addr", a_addr, 32'h0);
        chk("mrst_x15", a_wdata, 32'h0);
        chk("mrst_retire", {31'b0, a_ret}, 32'd0);
        reset = 1'b1;
        step();
        chk("mrst_fetch", {29'b0, a_state}, 32'd1);
        chk("mrst_fetch_addr", a_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dataflow_mc.md
Name: dataflow_mc

Overview:
- Single-clock, parametrised multicycle RV32I datapath with an internal sequencer and a valid/ready memory handshake.
- Replaces the three-clock scheme (instruction/PC/register-file clocks) with register enables on one clock.
- Adds wait-state tolerance, an optional reduced register file (RV32E) and a misalignment trap.
- Sits between the instruction decoder, which drives the selects combinationally from insn_out, and the unified memory port.

Parameters:
- XLEN, 32: datapath width; only 32 is supported, fixed for port sizing.
- NREG, 32: architectural registers, 32 or 16 (RV32E); register-index width RW = $clog2(NREG).
- RESET_PC, 32'h0000_0000: PC value after reset.
- TRAP_EN, 1: 1 enables misalignment trap; 0 ignores address low bits.

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low
- mem_req  out  1  memory request valid
- mem_we  out  1  write request, qualified by mem_req
- mem_ready  in  1  memory completes request this cycle
- addr  out  XLEN  memory address
- wdata  out  XLEN  store data (rs2 value)
- dout  in  XLEN  memory read data, valid when mem_ready=1
- pc_next_sel, pc_alu_sel, alu_a_sel, alu_b_sel, sub_sra  in  1 each  decoder selects, same meaning as the current dataflow
- rd_sel  in  2  0=mem_x, 1=imm, 2=alu, 3=pc+4/imm
- func3, mem_s  in  3 each  ALU function / load extension size
- is_load, is_store, rd_we  in  1 each  decoder class and writeback enable
- RSA, RSB, RD  in  RW each  register indices
- insn_out  out  XLEN  latched instruction
- EQ, LS, LU  out  1 each  ALU compare flags
- state  out  3  sequencer state encoding
- retire  out  1  one-cycle pulse in WB
- trap  out  1  sticky misalignment trap

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, pc=RESET_PC, insn=0, mdr=0, trap=0.
  - All registers 0; x0 hardwired 0.
  - Outputs: mem_req=0, mem_we=0, retire=0.
  - addr = pc = RESET_PC.
- Reset mid-operation: any state returns to IDLE next edge, with no PC or register-file write that cycle. An in-flight request is dropped: mem_req=0 the next cycle.
- IDLE: drives no request; goes to FETCH unconditionally.
- FETCH:
  - Drives mem_req=1, mem_we=0, addr=pc.
  - Holds until mem_ready=1, then latches insn=dout and goes to EXEC.
  - Zero-wait memory (ready in the first cycle) completes FETCH in 1 cycle.
- EXEC:
  - One cycle; the ALU evaluates from the regfile and imm.
  - Goes to MEM if is_load|is_store, else to WB.
  - If TRAP_EN and the access is misaligned, goes to TRAP instead. Misaligned means alu[1:0]!=0 for a word access, or alu[0]=1 for a halfword.
- MEM:
  - Drives mem_req=1, addr=alu, mem_we=is_store, wdata=rs2.
  - Holds until mem_ready=1. A load latches mdr=dout.
  - Then goes to WB.
- WB:
  - retire=1.
  - Regfile writes rd_val if rd_we and RD!=0; a write to x0 is discarded.
  - PC loads pc_next_sel ? alu : pc+(pc_alu_sel?imm:4).
  - Goes to FETCH.
  - If TRAP_EN and the new PC[1:0]!=0, the PC is still written, trap=1 and the next state is TRAP.
- TRAP: no requests; trap=1; left only by reset.
- Handshake rules:
  - While mem_req=1, addr, mem_we and wdata stay stable until the ready cycle inclusive.
  - mem_ready is ignored when mem_req=0.
  - Requests are never withdrawn except by reset.
- Stability across EXEC..WB: insn, pc and the regfile are unchanged, so combinational ALU results and flags are stable.
- Arithmetic:
  - pc+4 and pc+imm are modulo 2^XLEN; PC wrap-around at 0xFFFF_FFFC -> 0 is legal.
  - The load extension is applied to mdr according to mem_s.
- Latency with zero-wait memory: ALU/branch/jump instructions take 3 cycles; loads and stores take 4. Each wait cycle adds 1.
- Register-index bits above RW are absent; with NREG=16, RD=15 is the last register.

Decomposition:
- Package dataflow_pkg holds:
  - state encodings IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, TRAP=5;
  - rd_sel encodings;
  - mem_s size codes;
  - the PC increment constant 4.
- Sub-module dataflow_seq contains the FSM, handshake outputs, enable generation (insn_en, mdr_en, pc_en, rd_en) and the trap check.
- The top level instantiates the existing immx, memsx, regfile (parametrised NREG, with a write enable added), ALU, adders and muxes.

Test Plan:
- ADDI x1,x0,5 at RESET_PC=0, zero-wait -> state sequence IDLE,FETCH,EXEC,WB; x1=5; pc=4; retire high 1 cycle.
- Load with mem_ready delayed 3 cycles in MEM -> addr/mem_we stable all 4 cycles; loaded value written once; total 7 cycles.
- BEQ x0,x0,-4 at pc=8 -> pc=4 after WB; branch to 0xFFFF_FFFC+4 wraps to 0.
- SW with alu=0x102 -> EXEC goes to TRAP; no mem_req; trap=1 sticky; with TRAP_EN=0 the store issues.
- Reset driven low during a MEM wait -> next cycle IDLE, mem_req=0, pc=RESET_PC, no regfile write.
- NREG=16: write to RD=15 then read back via RSA=15 -> value returned; write to RD=0 -> x0 reads 0.
